// File: rtl/fetch_pipe_reg_if.sv
// IF/ID pipeline register bus: fetch-side inputs, decode-side outputs,
// plus the optional perf counters (live only with FETCH_PIPE_PERF_EN).
interface fetch_pipe_reg_if #(
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int CNT_W = 16
);
    logic [XLEN-1:0]  pc_in;
    logic [ILEN-1:0]  instr_in;
    logic             valid_in;
    logic             jal;
    logic             jalr;
    logic             branch_taken;
    logic             stall;
    logic [XLEN-1:0]  pc_out;
    logic [ILEN-1:0]  instr_out;
    logic             valid_out;
    logic             flushing;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output pc_in, instr_in, valid_in,
        output jal, jalr, branch_taken, stall,
        input  pc_out, instr_out, valid_out,
        input  flushing, bubble_cnt, stall_cnt
    );

    modport slave (
        input  pc_in, instr_in, valid_in,
        input  jal, jalr, branch_taken, stall,
        output pc_out, instr_out, valid_out,
        output flushing, bubble_cnt, stall_cnt
    );
endinterface

// File: rtl/fetch_pipe_reg.sv
// IF/ID pipeline register with stall hold and redirect bubble drain.
// Define FETCH_PIPE_PERF_EN to build the saturating bubble/stall counters.
module fetch_pipe_reg #(
    parameter int              XLEN         = 32,
    parameter int              ILEN         = 32,
    parameter int              FLUSH_CYCLES = 3,
    parameter logic [ILEN-1:0] NOP_INSN     = '0,
    parameter int              CNT_W        = 16
) (
    input logic             clk,
    input logic             rst,
    fetch_pipe_reg_if.slave bus
);

    localparam logic [3:0] DRAIN_INIT = 4'(FLUSH_CYCLES - 1);

    logic [3:0] dcnt;
    logic       redirect;
    logic       draining;
    logic       load_bubble;

    always_comb begin
        redirect    = bus.jal | bus.jalr | bus.branch_taken;
        draining    = (dcnt != 4'd0);
        load_bubble = redirect | draining;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.pc_out    <= '0;
            bus.instr_out <= NOP_INSN;
            bus.valid_out <= 1'b0;
            dcnt          <= 4'd0;
        end else if (redirect) begin
            bus.pc_out    <= '0;
            bus.instr_out <= NOP_INSN;
            bus.valid_out <= 1'b0;
            dcnt          <= DRAIN_INIT;
        end else if (draining) begin
            bus.pc_out    <= '0;
            bus.instr_out <= NOP_INSN;
            bus.valid_out <= 1'b0;
            dcnt          <= dcnt - 4'd1;
        end else if (!bus.stall) begin
            bus.pc_out    <= bus.pc_in;
            bus.instr_out <= bus.instr_in;
            bus.valid_out <= bus.valid_in;
        end
    end

    assign bus.flushing = draining;

`ifdef FETCH_PIPE_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] bcnt;
    logic [CNT_W-1:0] scnt;
    logic             hold;

    // stall only counts when it actually wins over redirect/drain
    assign hold = !load_bubble && bus.stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            bcnt <= '0;
            scnt <= '0;
        end else begin
            if (load_bubble && bcnt != CNT_MAX)
                bcnt <= bcnt + CNT_W'(1);
            if (hold && scnt != CNT_MAX)
                scnt <= scnt + CNT_W'(1);
        end
    end

    assign bus.bubble_cnt = bcnt;
    assign bus.stall_cnt  = scnt;
`else
    assign bus.bubble_cnt = '0;
    assign bus.stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_fetch_pipe_reg.sv
// Bench for fetch_pipe_reg: directed scenarios plus random traffic
// against a cycle-indexed reference model; two configs run in lockstep.
module tb_fetch_pipe_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_pipe_reg_if #(.XLEN(32), .ILEN(32), .CNT_W(16)) bus ();
    fetch_pipe_reg_if #(.XLEN(32), .ILEN(32), .CNT_W(4))  bus2 ();

    assign bus2.pc_in        = bus.pc_in;
    assign bus2.instr_in     = bus.instr_in;
    assign bus2.valid_in     = bus.valid_in;
    assign bus2.jal          = bus.jal;
    assign bus2.jalr         = bus.jalr;
    assign bus2.branch_taken = bus.branch_taken;
    assign bus2.stall        = bus.stall;

    fetch_pipe_reg #(
        .XLEN(32), .ILEN(32), .FLUSH_CYCLES(3), .NOP_INSN(NOP), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    fetch_pipe_reg #(
        .XLEN(32), .ILEN(32), .FLUSH_CYCLES(1), .NOP_INSN(NOP), .CNT_W(4)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    // Model: an edge loads a bubble iff it is within FL edges of the
    // most recent redirect edge (a redirect edge itself counts as 0).
    int          cyc = 0;
    int          FL[2]  = '{3, 1};
    int          SAT[2] = '{65535, 15};
    int          last_redir[2] = '{-1000, -1000};
    logic [31:0] e_pc[2];
    logic [31:0] e_ins[2];
    logic        e_v[2];
    logic        e_fl[2];
    int          e_bc[2] = '{0, 0};
    int          e_sc[2] = '{0, 0};

    function automatic int perf(input int v);
`ifdef FETCH_PIPE_PERF_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic cycle(input logic [31:0] p, input logic [31:0] i,
                         input logic v, input logic j, input logic jr,
                         input logic bt, input logic st);
        bit red;
        bit bub;
        bus.pc_in        = p;
        bus.instr_in     = i;
        bus.valid_in     = v;
        bus.jal          = j;
        bus.jalr         = jr;
        bus.branch_taken = bt;
        bus.stall        = st;
        @(posedge clk);
        #1;
        cyc++;
        red = j | jr | bt;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                last_redir[k] = -1000;
                e_pc[k] = '0; e_ins[k] = NOP; e_v[k] = 1'b0;
                e_bc[k] = 0; e_sc[k] = 0;
                e_fl[k] = 1'b0;
            end else begin
                if (red) last_redir[k] = cyc;
                bub = (cyc - last_redir[k]) < FL[k];
                if (bub) begin
                    e_pc[k] = '0; e_ins[k] = NOP; e_v[k] = 1'b0;
                    if (e_bc[k] < SAT[k]) e_bc[k]++;
                end else if (st) begin
                    if (e_sc[k] < SAT[k]) e_sc[k]++;
                end else begin
                    e_pc[k] = p; e_ins[k] = i; e_v[k] = v;
                end
                e_fl[k] = (cyc + 1 - last_redir[k]) < FL[k];
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) cycle($urandom, $urandom, 1'($urandom), 1'($urandom),
                         1'($urandom), 1'($urandom), 1'($urandom));
        checks++;
        if (bus.pc_out !== 32'h0) begin
            errors++; $display("FAIL reset_pc got %h want 0", bus.pc_out);
        end
        checks++;
        if (bus.instr_out !== NOP) begin
            errors++;
            $display("FAIL reset_instr got %h want %h", bus.instr_out, NOP);
        end
        checks++;
        if (bus.valid_out !== 1'b0 || bus.flushing !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got v=%b f=%b want 0 0",
                     bus.valid_out, bus.flushing);
        end
        checks++;
        if (bus.bubble_cnt !== 16'd0 || bus.stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_perf got %0d %0d want 0 0",
                     bus.bubble_cnt, bus.stall_cnt);
        end
        rst = 1'b1;
        cycle(32'h100, 32'h0050_0093, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.pc_out !== 32'h100 || bus.instr_out !== 32'h0050_0093 ||
            bus.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got %h %h %b want 100 00500093 1",
                     bus.pc_out, bus.instr_out, bus.valid_out);
        end
    endtask

    task automatic test_straight();
        logic [31:0] ins;
        for (int k = 0; k < 3; k++) begin
            ins = $urandom;
            cycle(32'(k * 4), ins, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.pc_out !== 32'(k * 4) || bus.instr_out !== ins ||
                bus.valid_out !== 1'b1) begin
                errors++;
                $display("FAIL straight_%0d got %h %h %b want %h %h 1", k,
                         bus.pc_out, bus.instr_out, bus.valid_out,
                         32'(k * 4), ins);
            end
        end
    endtask

    task automatic test_redirect();
        logic exp_v[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic exp_fl[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int   b0 = e_bc[0];
        logic [31:0] ins;
        for (int k = 0; k < 4; k++) begin
            ins = $urandom;
            if (k == 0) cycle(32'h20, ins, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            else        cycle(32'h40, ins, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (bus.valid_out !== exp_v[k] || bus.flushing !== exp_fl[k] ||
                bus.pc_out !== (exp_v[k] ? 32'h40 : 32'h0) ||
                (!exp_v[k] && bus.instr_out !== NOP)) begin
                errors++;
                $display("FAIL redirect_e%0d got pc=%h i=%h v=%b f=%b",
                         k + 1, bus.pc_out, bus.instr_out,
                         bus.valid_out, bus.flushing);
            end
        end
        checks++;
        if (bus.bubble_cnt !== 16'(perf(b0 + 3))) begin
            errors++;
            $display("FAIL redirect_bcnt got %0d want %0d",
                     bus.bubble_cnt, perf(b0 + 3));
        end
    endtask

    task automatic test_drain_restart();
        logic exp_v[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic exp_fl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 6; k++) begin
            cycle(32'h80 + 32'(k * 4), $urandom, 1'b1, 1'b0,
                  1'(k == 1), 1'(k == 0), 1'b0);
            checks++;
            if (bus.valid_out !== exp_v[k] || bus.flushing !== exp_fl[k]) begin
                errors++;
                $display("FAIL drain_e%0d got v=%b f=%b want v=%b f=%b", k,
                         bus.valid_out, bus.flushing, exp_v[k], exp_fl[k]);
            end
        end
        checks++;
        if (bus.pc_out !== 32'h94) begin
            errors++; $display("FAIL drain_resume got %h want 94", bus.pc_out);
        end
    endtask

    task automatic test_stall();
        int s0;
        cycle(32'h10, 32'hdead_beef, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        s0 = e_sc[0];
        for (int k = 0; k < 3; k++) begin
            cycle($urandom, $urandom, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            checks++;
            if (bus.pc_out !== 32'h10 || bus.instr_out !== 32'hdead_beef ||
                bus.valid_out !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold_%0d got %h %h %b want 10 deadbeef 1",
                         k, bus.pc_out, bus.instr_out, bus.valid_out);
            end
        end
        checks++;
        if (bus.stall_cnt !== 16'(perf(s0 + 3))) begin
            errors++;
            $display("FAIL stall_cnt got %0d want %0d",
                     bus.stall_cnt, perf(s0 + 3));
        end
        for (int k = 0; k < 3; k++)
            cycle($urandom, $urandom, 1'b1, 1'(k == 0), 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.valid_out !== 1'b0 || bus.instr_out !== NOP ||
            bus.stall_cnt !== 16'(perf(s0 + 3))) begin
            errors++;
            $display("FAIL stall_vs_jal got v=%b i=%h sc=%0d want 0 %h %0d",
                     bus.valid_out, bus.instr_out, bus.stall_cnt,
                     NOP, perf(s0 + 3));
        end
        cycle($urandom, $urandom, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus.valid_out !== 1'b0 || bus.pc_out !== 32'h0 ||
            bus.stall_cnt !== 16'(perf(s0 + 4))) begin
            errors++;
            $display("FAIL stall_bubble got v=%b pc=%h sc=%0d want 0 0 %0d",
                     bus.valid_out, bus.pc_out, bus.stall_cnt, perf(s0 + 4));
        end
    endtask

    task automatic test_flush1();
        cycle($urandom, $urandom, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus2.valid_out !== 1'b0 || bus2.flushing !== 1'b0) begin
            errors++;
            $display("FAIL flush1_bubble got v=%b f=%b want 0 0",
                     bus2.valid_out, bus2.flushing);
        end
        cycle(32'h200, $urandom, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus2.pc_out !== 32'h200 || bus2.valid_out !== 1'b1) begin
            errors++;
            $display("FAIL flush1_resume got %h %b want 200 1",
                     bus2.pc_out, bus2.valid_out);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) != 0);
            cycle($urandom, $urandom, 1'($urandom),
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) == 0));
            checks++;
            if (bus.pc_out !== e_pc[0] || bus.instr_out !== e_ins[0] ||
                bus.valid_out !== e_v[0] || bus.flushing !== e_fl[0] ||
                bus.bubble_cnt !== 16'(perf(e_bc[0])) ||
                bus.stall_cnt !== 16'(perf(e_sc[0]))) begin
                errors++;
                $display("FAIL rand3_%0d got %h %h %b %b %0d %0d want %h %h %b %b %0d %0d",
                         n, bus.pc_out, bus.instr_out, bus.valid_out,
                         bus.flushing, bus.bubble_cnt, bus.stall_cnt,
                         e_pc[0], e_ins[0], e_v[0], e_fl[0],
                         perf(e_bc[0]), perf(e_sc[0]));
            end
            checks++;
            if (bus2.pc_out !== e_pc[1] || bus2.instr_out !== e_ins[1] ||
                bus2.valid_out !== e_v[1] || bus2.flushing !== e_fl[1] ||
                bus2.bubble_cnt !== 4'(perf(e_bc[1])) ||
                bus2.stall_cnt !== 4'(perf(e_sc[1]))) begin
                errors++;
                $display("FAIL rand1_%0d got %h %h %b %b %0d %0d want %h %h %b %b %0d %0d",
                         n, bus2.pc_out, bus2.instr_out, bus2.valid_out,
                         bus2.flushing, bus2.bubble_cnt, bus2.stall_cnt,
                         e_pc[1], e_ins[1], e_v[1], e_fl[1],
                         perf(e_bc[1]), perf(e_sc[1]));
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_saturation();
        logic [3:0] want;
`ifdef FETCH_PIPE_PERF_EN
        want = 4'd15;
`else
        want = 4'd0;
`endif
        rst = 1'b0;
        cycle($urandom, $urandom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 20; k++)
            cycle($urandom, $urandom, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus2.bubble_cnt !== want) begin
            errors++;
            $display("FAIL sat_bcnt got %0d want %0d", bus2.bubble_cnt, want);
        end
        cycle($urandom, $urandom, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus2.bubble_cnt !== want) begin
            errors++;
            $display("FAIL sat_hold got %0d want %0d", bus2.bubble_cnt, want);
        end
        rst = 1'b0;
        cycle($urandom, $urandom, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus2.bubble_cnt !== 4'd0 || bus.bubble_cnt !== 16'd0) begin
            errors++;
            $display("FAIL sat_reset got %0d %0d want 0 0",
                     bus2.bubble_cnt, bus.bubble_cnt);
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_straight();
        test_redirect();
        test_drain_restart();
        test_stall();
        test_flush1();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
